// File: rtl/conware_pkg.sv
// Shared definitions for the Game-of-Life frame path: board geometry defaults
// and the frame sequencer state encoding.
package conware_pkg;

  localparam int unsigned DEFAULT_WIDTH  = 8;
  localparam int unsigned DEFAULT_HEIGHT = 8;
  localparam int unsigned ROW_LAST       = DEFAULT_HEIGHT - 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    LOAD  = 3'd2,
    OFFER = 3'd3,
    GEN   = 3'd4
  } seq_state_t;

  // Index of the final row for a board of the given height.
  function automatic int unsigned last_row(input int unsigned height);
    return height - 1;
  endfunction

endpackage

// File: rtl/conware_frame_sequencer.sv
// Frame sequencer: reads the board row by row from memory, offers each row to
// the serializer over valid/ready, optionally requests a generation step after
// the last row, and repeats in continuous mode until stopped.
module conware_frame_sequencer
  import conware_pkg::*;
#(
  parameter int unsigned WIDTH  = DEFAULT_WIDTH,
  parameter int unsigned HEIGHT = DEFAULT_HEIGHT,
  parameter int unsigned AWIDTH = 3,
  parameter int unsigned CWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              continuous,
  input  logic              stop,
  input  logic              gen_en,
  output logic              busy,
  output logic              rd_en,
  output logic [AWIDTH-1:0] rd_addr,
  input  logic [WIDTH-1:0]  rd_data,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sof,
  output logic              out_eof,
  output logic              gen_req,
  input  logic              gen_ack,
  output logic              frame_done,
  output logic [CWIDTH-1:0] frame_count
);

  localparam logic [AWIDTH-1:0] ROW_END = AWIDTH'(last_row(HEIGHT));

  seq_state_t        state_q, state_d;
  logic [AWIDTH-1:0] row_q, row_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              loop_q, loop_d;
  logic              stop_pend_q, stop_pend_d;
  logic [CWIDTH-1:0] count_q, count_d;
  logic              frame_end;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      row_q       <= '0;
      data_q      <= '0;
      loop_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      data_q      <= data_d;
      loop_q      <= loop_d;
      stop_pend_q <= stop_pend_d;
      count_q     <= count_d;
    end
  end

  // Next-state, row/frame bookkeeping and handshake outputs.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    data_d      = data_q;
    loop_d      = loop_q;
    stop_pend_d = stop_pend_q;
    count_d     = count_q;
    frame_end   = 1'b0;
    rd_en       = 1'b0;
    out_valid   = 1'b0;
    gen_req     = 1'b0;

    case (state_q)
      IDLE: begin
        stop_pend_d = 1'b0;
        if (start && !stop) begin
          state_d = READ;
          row_d   = '0;
          loop_d  = continuous;
        end
      end
      READ: begin
        rd_en   = 1'b1;
        state_d = LOAD;
      end
      LOAD: begin
        data_d  = rd_data;
        state_d = OFFER;
      end
      OFFER: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (row_q == ROW_END) begin
            if (gen_en) state_d = GEN;
            else        frame_end = 1'b1;
          end else begin
            row_d   = row_q + 1'b1;
            state_d = READ;
          end
        end
      end
      GEN: begin
        gen_req = 1'b1;
        if (gen_ack) frame_end = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && stop) stop_pend_d = 1'b1;

    // Frame end is folded into the OFFER/GEN exit cycle rather than a state of
    // its own; a stop arriving in that same cycle also ends the loop.
    if (frame_end) begin
      count_d = count_q + 1'b1;
      if (loop_q && !stop_pend_q && !stop) begin
        state_d = READ;
        row_d   = '0;
      end else begin
        state_d     = IDLE;
        row_d       = '0;
        loop_d      = 1'b0;
        stop_pend_d = 1'b0;
      end
    end
  end

  assign busy        = (state_q != IDLE);
  assign rd_addr     = row_q;
  assign out_data    = data_q;
  assign out_sof     = out_valid && (row_q == '0);
  assign out_eof     = out_valid && (row_q == ROW_END);
  assign frame_done  = frame_end;
  assign frame_count = count_q;

endmodule

// File: tb/tb_conware_frame_sequencer.sv
// Directed bench for conware_frame_sequencer on an 8x8 board with a 4-bit
// frame counter; board memory returns 8'h11*addr one cycle after rd_en.
module tb_conware_frame_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       continuous = 1'b0;
  logic       stop = 1'b0;
  logic       gen_en = 1'b0;
  logic       busy;
  logic       rd_en;
  logic [2:0] rd_addr;
  logic [7:0] rd_data = '0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       out_sof;
  logic       out_eof;
  logic       gen_req;
  logic       gen_ack = 1'b0;
  logic       frame_done;
  logic [3:0] frame_count;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [8];
  logic [9:0] offers [$];
  int         fd_total = 0;
  int         rd_total = 0;

  conware_frame_sequencer #(
    .WIDTH (8),
    .HEIGHT(8),
    .AWIDTH(3),
    .CWIDTH(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .continuous (continuous),
    .stop       (stop),
    .gen_en     (gen_en),
    .busy       (busy),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sof    (out_sof),
    .out_eof    (out_eof),
    .gen_req    (gen_req),
    .gen_ack    (gen_ack),
    .frame_done (frame_done),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  // Board memory: one-cycle read latency.
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  // Mid-cycle recorder of accepted rows, frame completions and reads.
  always @(negedge clk) begin
    if (out_valid && out_ready) offers.push_back({out_data, out_sof, out_eof});
    if (frame_done) fd_total++;
    if (rd_en) rd_total++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic cont);
    step(); start = 1'b1; continuous = cont; #1;
    step(); start = 1'b0; #1;
  endtask

  task automatic wait_idle(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      step(); #1;
      if (!busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    #1;
    checks++;
    if ({busy, rd_en, out_valid, out_sof, out_eof, gen_req, frame_done} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 0000000",
               {busy, rd_en, out_valid, out_sof, out_eof, gen_req, frame_done});
    end
    checks++;
    if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", out_data); end
    checks++;
    if (frame_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", frame_count); end
    step(); rst = 1'b0; #1;
  endtask

  task automatic test_single_frame();
    int base, fd0;
    bit ok;
    logic [9:0] e;
    base = offers.size(); fd0 = fd_total;
    out_ready = 1'b1; gen_en = 1'b0;
    step(); start = 1'b1; continuous = 1'b0; #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_c0 got %b exp 0", out_valid); end
    step(); start = 1'b0; #1;
    checks++;
    if ({rd_en, rd_addr} !== 4'b1_000) begin errors++; $display("FAIL lat_read got %b exp 1000", {rd_en, rd_addr}); end
    step(); #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_c2 got %b exp 0", out_valid); end
    step(); #1;
    checks++;
    if ({out_valid, out_sof, out_data} !== {2'b11, 8'h00}) begin
      errors++; $display("FAIL lat_c3 got %b/%b/%h exp 1/1/00", out_valid, out_sof, out_data);
    end
    wait_idle(60, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_timeout got busy exp idle"); end
    checks++;
    if (offers.size() - base !== 8) begin
      errors++; $display("FAIL single_nrows got %0d exp 8", offers.size() - base);
    end else begin
      for (int i = 0; i < 8; i++) begin
        e = {8'(8'h11 * i), (i == 0), (i == 7)};
        checks++;
        if (offers[base + i] !== e) begin
          errors++; $display("FAIL single_row%0d got %h exp %h", i, offers[base + i], e);
        end
      end
    end
    checks++;
    if (fd_total - fd0 !== 1) begin errors++; $display("FAIL single_fd got %0d exp 1", fd_total - fd0); end
    checks++;
    if (frame_count !== 4'd1) begin errors++; $display("FAIL single_count got %0d exp 1", frame_count); end
  endtask

  task automatic test_backpressure();
    int base;
    bit ok, found;
    logic [9:0] e;
    bit bad;
    base = offers.size(); out_ready = 1'b1;
    pulse_start(1'b0);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(); #1;
      if (rd_en && rd_addr == 3'd3) begin found = 1'b1; break; end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL bp_find_row3 got none exp read"); end
    out_ready = 1'b0;
    step(); #1;
    for (int k = 0; k < 5; k++) begin
      step(); #1;
      checks++;
      if ({out_valid, out_data, rd_en} !== {1'b1, 8'h33, 1'b0}) begin
        errors++; $display("FAIL bp_hold%0d got %b/%h/%b exp 1/33/0", k, out_valid, out_data, rd_en);
      end
    end
    step(); out_ready = 1'b1; #1;
    checks++;
    if ({out_valid, out_data} !== {1'b1, 8'h33}) begin
      errors++; $display("FAIL bp_accept got %b/%h exp 1/33", out_valid, out_data);
    end
    step(); #1;
    checks++;
    if ({rd_en, rd_addr} !== 4'b1_100) begin errors++; $display("FAIL bp_next_read got %b exp 1100", {rd_en, rd_addr}); end
    wait_idle(60, ok);
    bad = (offers.size() - base != 8);
    if (!bad) begin
      for (int i = 0; i < 8; i++) begin
        e = {8'(8'h11 * i), (i == 0), (i == 7)};
        if (offers[base + i] !== e) bad = 1'b1;
      end
    end
    checks++;
    if (!ok || bad) begin errors++; $display("FAIL bp_rows got ok=%0b bad=%0b exp ok=1 bad=0", ok, bad); end
    checks++;
    if (frame_count !== 4'd2) begin errors++; $display("FAIL bp_count got %0d exp 2", frame_count); end
  endtask

  task automatic test_gen();
    bit found;
    gen_en = 1'b1; out_ready = 1'b1;
    pulse_start(1'b0);
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step(); #1;
      if (out_valid && out_eof) begin found = 1'b1; break; end
    end
    checks++;
    if (!found || {frame_done, gen_req} !== 2'b00) begin
      errors++; $display("FAIL gen_eof got found=%0b fd=%b req=%b exp 1/0/0", found, frame_done, gen_req);
    end
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k == 4) gen_ack = 1'b1;
      #1;
      checks++;
      if ({gen_req, frame_done} !== {1'b1, (k == 4)}) begin
        errors++; $display("FAIL gen_cycle%0d got req=%b fd=%b exp 1/%0d", k, gen_req, frame_done, (k == 4));
      end
    end
    step(); gen_ack = 1'b0; #1;
    checks++;
    if ({gen_req, busy, frame_count} !== {2'b00, 4'd3}) begin
      errors++; $display("FAIL gen_after got req=%b busy=%b cnt=%0d exp 0/0/3", gen_req, busy, frame_count);
    end
    step(); gen_ack = 1'b1; #1;
    step(); gen_ack = 1'b0; #1;
    step(); #1;
    checks++;
    if ({busy, gen_req, frame_count} !== {2'b00, 4'd3}) begin
      errors++; $display("FAIL gen_stray_ack got busy=%b req=%b cnt=%0d exp 0/0/3", busy, gen_req, frame_count);
    end
    gen_en = 1'b0;
  endtask

  task automatic test_continuous_stop();
    int frames, rd0;
    bit sent;
    rst = 1'b1; step(); step(); rst = 1'b0; #1;
    out_ready = 1'b1;
    pulse_start(1'b1);
    frames = 0; sent = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step(); stop = 1'b0; #1;
      if (frame_done) frames++;
      if (!busy) break;
      if (frames == 2 && rd_en && rd_addr == 3'd2 && !sent) begin stop = 1'b1; sent = 1'b1; end
    end
    stop = 1'b0;
    checks++;
    if ({sent, busy} !== 2'b10 || frames != 3) begin
      errors++; $display("FAIL cont_stop got sent=%b busy=%b frames=%0d exp 1/0/3", sent, busy, frames);
    end
    checks++;
    if (frame_count !== 4'd3) begin errors++; $display("FAIL cont_count got %0d exp 3", frame_count); end
    rd0 = rd_total;
    repeat (10) step();
    checks++;
    if (rd_total != rd0 || busy !== 1'b0) begin
      errors++; $display("FAIL cont_quiet got reads=%0d busy=%b exp 0/0", rd_total - rd0, busy);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    bit found, ok;
    out_ready = 1'b1;
    pulse_start(1'b0);
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step(); #1;
      if (out_valid && out_data == 8'h55) begin found = 1'b1; break; end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL rstmid_find got none exp row5"); end
    rst = 1'b1;
    step(); #1;
    checks++;
    if ({out_valid, busy, frame_count, out_data} !== {2'b00, 4'd0, 8'h00}) begin
      errors++; $display("FAIL rstmid_clear got v=%b busy=%b cnt=%0d data=%h exp 0/0/0/00",
                         out_valid, busy, frame_count, out_data);
    end
    rst = 1'b0;
    base = offers.size();
    pulse_start(1'b0);
    wait_idle(60, ok);
    checks++;
    if (!ok || offers.size() - base != 8 || offers[base] !== {8'h00, 2'b10}) begin
      errors++; $display("FAIL rstmid_restart got ok=%0b n=%0d first=%h exp 1/8/%h",
                         ok, offers.size() - base, (offers.size() > base) ? offers[base] : 10'h0, {8'h00, 2'b10});
    end
    checks++;
    if (frame_count !== 4'd1) begin errors++; $display("FAIL rstmid_count got %0d exp 1", frame_count); end
  endtask

  task automatic test_start_stop_idle();
    step(); start = 1'b1; stop = 1'b1; continuous = 1'b0; #1;
    step(); start = 1'b0; stop = 1'b0; #1;
    checks++;
    if ({busy, rd_en} !== 2'b00) begin errors++; $display("FAIL startstop_idle got %b exp 00", {busy, rd_en}); end
    step(); #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL startstop_idle2 got %b exp 0", busy); end
  endtask

  task automatic test_back_to_back();
    int base, fd0;
    bit ok, found, bad;
    logic [9:0] e;
    base = offers.size(); fd0 = fd_total; out_ready = 1'b1;
    pulse_start(1'b0);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(); #1;
      if (rd_en && rd_addr == 3'd3) begin found = 1'b1; break; end
    end
    start = 1'b1;
    step(); start = 1'b0; #1;
    wait_idle(60, ok);
    bad = (offers.size() - base != 8);
    if (!bad) begin
      for (int i = 0; i < 8; i++) begin
        e = {8'(8'h11 * i), (i == 0), (i == 7)};
        if (offers[base + i] !== e) bad = 1'b1;
      end
    end
    checks++;
    if (!found || !ok || bad) begin
      errors++; $display("FAIL b2b_rows got found=%0b ok=%0b bad=%0b exp 1/1/0", found, ok, bad);
    end
    checks++;
    if (fd_total - fd0 != 1 || frame_count !== 4'd2) begin
      errors++; $display("FAIL b2b_count got fd=%0d cnt=%0d exp 1/2", fd_total - fd0, frame_count);
    end
  endtask

  task automatic test_wrap();
    int frames;
    bit sent;
    rst = 1'b1; step(); step(); rst = 1'b0; #1;
    out_ready = 1'b1;
    pulse_start(1'b1);
    frames = 0; sent = 1'b0;
    for (int i = 0; i < 700; i++) begin
      step(); stop = 1'b0; #1;
      if (frame_done) frames++;
      if (!busy) break;
      if (frames == 15 && !sent && !frame_done) begin
        checks++;
        if (frame_count !== 4'd15) begin errors++; $display("FAIL wrap_15 got %0d exp 15", frame_count); end
        stop = 1'b1; sent = 1'b1;
      end
    end
    stop = 1'b0;
    checks++;
    if (frames != 16 || busy !== 1'b0 || frame_count !== 4'd0) begin
      errors++; $display("FAIL wrap_0 got frames=%0d busy=%b cnt=%0d exp 16/0/0", frames, busy, frame_count);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 8'(8'h11 * i);
    test_reset();
    test_single_frame();
    test_backpressure();
    test_gen();
    test_continuous_stop();
    test_reset_mid();
    test_start_stop_idle();
    test_back_to_back();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got running exp finished");
    $fatal(1, "watchdog expired");
  end

endmodule
